arb_rsp_router: RTL
===================

# arb_rsp_router

Return-path companion to the priority arbiter: it records the index of each grant accepted by the shared downstream resource and routes that resource's in-order responses back to the originating port. It sits between the shared resource's response channel and the NUM_PORTS requesters, tracking up to DEPTH outstanding transactions in a tag FIFO.

## Interface
- NUM_PORTS, 16: number of requester ports; width of the one-hot grant vector.
- DATA_W, 32: response payload width.
- DEPTH, 8: maximum outstanding transactions; power of two, ≥2.
- IDX_W, $clog2(NUM_PORTS): stored tag width; derived, do not override.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- gnt_i  in  NUM_PORTS  one-hot grant vector from the arbiter.
- gnt_fire_i  in  1  the granted request is accepted downstream this cycle.
- issue_ready_o  out  1  tag FIFO not full; upstream must not assert gnt_fire_i while low.
- rsp_valid_i  in  1  downstream response valid.
- rsp_data_i  in  DATA_W  downstream response payload.
- rsp_ready_o  out  1  response accepted this cycle.
- port_rsp_valid_o  out  NUM_PORTS  per-port response valid; at most one bit set.
- port_rsp_data_o  out  DATA_W  shared response payload bus, equal to rsp_data_i.
- port_rsp_ready_i  in  NUM_PORTS  per-port response ready.
- outstanding_o  out  $clog2(DEPTH+1)  current tag FIFO occupancy.
- err_o  out  1  sticky protocol-error flag.

## Operation
- Push: when gnt_fire_i && issue_ready_o, encode gnt_i to an index and write it at the tail.
- Head index h is valid when the FIFO is non-empty.
- port_rsp_valid_o[h] = rsp_valid_i && !empty. All other bits are 0.
- rsp_ready_o = !empty && port_rsp_ready_i[h].
- Pop: when rsp_valid_i && rsp_ready_o, advance the head.
- Responses are delivered strictly in grant order. No reordering, no dropping.
- issue_ready_o = (count < DEPTH). It depends on registered state only; a same-cycle pop does not free a slot for a same-cycle push.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Empty FIFO: rsp_ready_o = 0 and all port_rsp_valid_o = 0. A response arriving with nothing outstanding stalls and is not accepted.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count register distinguishes full from empty.
- Combinational paths: rsp_valid_i and port_rsp_ready_i to the outputs. No path from gnt_i to the response outputs.

## Timing
- Reset values:
  - issue_ready_o = 1
  - rsp_ready_o = 0
  - port_rsp_valid_o = 0
  - outstanding_o = 0
  - err_o = 0
- port_rsp_data_o follows rsp_data_i and has no reset value.
- A grant pushed in cycle N is visible at the head, and routable, from cycle N+1. outstanding_o increments at N+1.
- A pop in cycle N decrements outstanding_o at N+1, and the next head is visible at N+1.
- Full throughput: one push and one pop per cycle sustained.
- Reset asserted mid-operation: on the next edge the FIFO empties and err_o clears. Outstanding tags are discarded; upstream must not present responses belonging to pre-reset transactions.

## Configuration
- ARB_RSP_ROUTER_CHECK_EN defined:
  - gnt_fire_i with gnt_i zero or multi-hot is ignored (no push), and err_o is set on the next edge.
  - rsp_valid_i while empty sets err_o on the next edge.
  - err_o stays set until rst_i.
- ARB_RSP_ROUTER_CHECK_EN undefined:
  - err_o is tied to 0.
  - A non-one-hot gnt_i pushes the lowest set bit index; zero pushes index 0.
  - No other behaviour changes.

## Test plan
- Reset, then fire gnt_i=16'h0004 → outstanding_o=1 next cycle. Then rsp_valid_i with data 32'hA5A5_0001 and port_rsp_ready_i[2]=1 → port_rsp_valid_o=16'h0004, data routed, outstanding_o returns to 0.
- Fire grants to ports 3, 0, 15. Return three responses with all readies high → delivered to 3, 0, 15 in that order, one per cycle.
- Fill to 8 outstanding → issue_ready_o=0. Pop and attempt a push in the same cycle → push refused, outstanding_o=7, then issue_ready_o=1.
- Hold port_rsp_ready_i[5]=0 with head=5 → rsp_ready_o=0 and payload held. Release → accepted in that cycle.
- Push and pop every cycle for 20 cycles with indices 0..19 mod 16 → outstanding_o constant, order preserved across pointer wrap.
- With CHECK_EN: fire gnt_i=16'h0003 → no push, err_o=1. Then rsp_valid_i while empty → still 1, rsp_ready_o=0. rst_i → err_o=0.

Source files
------------

// File: rtl/arb_rsp_router.sv
// Return-path router: records granted port indices in a tag FIFO and steers the
// in-order downstream responses back to the originating port.
// Optional protocol checking is enabled with `define ARB_RSP_ROUTER_CHECK_EN.
module arb_rsp_router #(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_PORTS-1:0]         gnt_i,
  input  logic                         gnt_fire_i,
  output logic                         issue_ready_o,
  input  logic                         rsp_valid_i,
  input  logic [DATA_W-1:0]            rsp_data_i,
  output logic                         rsp_ready_o,
  output logic [NUM_PORTS-1:0]         port_rsp_valid_o,
  output logic [DATA_W-1:0]            port_rsp_data_o,
  input  logic [NUM_PORTS-1:0]         port_rsp_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         err_o
);
  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][IDX_W-1:0] tags_q;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        err_q, err_d;

  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] head_idx;
  logic             gnt_onehot;
  logic             empty;
  logic             push, pop;

  // Lowest set bit wins; an all-zero grant encodes to index 0.
  always_comb begin
    gnt_idx = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      if (gnt_i[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign gnt_onehot = (gnt_i != '0) && ((gnt_i & (gnt_i - 1'b1)) == '0);

  assign empty         = (count_q == '0);
  assign head_idx      = tags_q[rd_ptr_q];
  assign issue_ready_o = (count_q < CNT_W'(DEPTH));
  assign rsp_ready_o   = !empty && port_rsp_ready_i[head_idx];
  assign pop           = rsp_valid_i && rsp_ready_o;

`ifdef ARB_RSP_ROUTER_CHECK_EN
  assign push  = gnt_fire_i && issue_ready_o && gnt_onehot;
  assign err_d = err_q || (gnt_fire_i && !gnt_onehot) || (rsp_valid_i && empty);
`else
  assign push  = gnt_fire_i && issue_ready_o;
  assign err_d = 1'b0;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_rsp_valid_o[p] = rsp_valid_i && !empty && (head_idx == IDX_W'(p));
  end

  assign port_rsp_data_o = rsp_data_i;
  assign outstanding_o   = count_q;
  assign err_o           = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (push) tags_q[wr_ptr_q] <= gnt_idx;
  end

  logic unused_ok;
  assign unused_ok = gnt_onehot;
endmodule
